skinny_sbox8_dom1_sni_array: RTL and testbench

- NSBOX parallel first-order DOM-Indep masked SKINNY-128 8-bit S-boxes.
- Single posedge clock domain; valid/ready handshake.
- Shares and refresh randomness are captured internally, so the caller need not hold inputs stable.
- Serves as the S-box layer of the masked Romulus/SKINNY datapath: NSBOX=16 for a full state, NSBOX=4 for a row-serial datapath.

---
 rtl/skinny_sbox8_dom1_sni_array.sv | 173 +++++++++++++++++
 tb/tb_skinny_sbox8_dom1_sni_array.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox8_dom1_sni_array.sv
// NSBOX parallel first-order DOM-indep masked SKINNY-128 8-bit S-boxes.
// Four registered gate layers; shares and refresh randomness are captured on accept.
module skinny_sbox8_dom1_sni_array #(
  parameter int unsigned NSBOX   = 16,
  parameter bit          ZEROIZE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*NSBOX-1:0] si0,
  input  logic [8*NSBOX-1:0] si1,
  input  logic [8*NSBOX-1:0] r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*NSBOX-1:0] bo0,
  output logic [8*NSBOX-1:0] bo1
);

  localparam int unsigned W = 8 * NSBOX;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    L4   = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0] s0_q, s0_d, s1_q, s1_d, r_q, r_d;
  // Gate flops: bit 8k+i holds gate a_i of S-box k
  logic [W-1:0] g0_q, g0_d, g1_q, g1_d, t0_q, t0_d, t1_q, t1_d;
  logic [W-1:0] cg0, cg1, ct0, ct1;
  logic [W-1:0] f0, f1;
  logic [W-1:0] lsel;
  logic [7:0]   lmask;
  logic         accept;
  logic         out_hs;

  // DOM-indep NOR-XOR gate; returns {g0, g1, t0, t1}, cross terms refreshed by rr
  function automatic logic [3:0] dom_gate(input logic x0, input logic x1,
                                          input logic y0, input logic y1,
                                          input logic z0, input logic z1,
                                          input logic rr);
    dom_gate = {(x0 & y0) ^ z0, (~x1 & ~y1) ^ z1, (~y1 & x0) ^ rr, (~x1 & y0) ^ rr};
  endfunction

  assign f0 = t0_q ^ g0_q;
  assign f1 = t1_q ^ g1_q;

  for (genvar k = 0; k < NSBOX; k++) begin : g_sbox
    logic [7:0]      b0, b1, p0, p1, rr;
    logic [7:0][3:0] gv;

    assign b0 = s0_q[8*k +: 8];
    assign b1 = s1_q[8*k +: 8];
    assign p0 = f0[8*k +: 8];
    assign p1 = f1[8*k +: 8];
    assign rr = r_q[8*k +: 8];

    assign gv[0] = dom_gate(b0[7], b1[7], b0[6], b1[6], b0[4], b1[4], rr[0]);
    assign gv[1] = dom_gate(b0[3], b1[3], b0[2], b1[2], b0[0], b1[0], rr[1]);
    assign gv[2] = dom_gate(b0[2], b1[2], b0[1], b1[1], b0[6], b1[6], rr[2]);
    assign gv[3] = dom_gate(p0[0], p1[0], p0[1], p1[1], b0[5], b1[5], rr[3]);
    assign gv[4] = dom_gate(p0[1], p1[1], b0[3], b1[3], b0[1], b1[1], rr[4]);
    assign gv[5] = dom_gate(p0[2], p1[2], p0[3], p1[3], b0[7], b1[7], rr[5]);
    assign gv[6] = dom_gate(p0[3], p1[3], p0[0], p1[0], b0[3], b1[3], rr[6]);
    assign gv[7] = dom_gate(p0[4], p1[4], p0[5], p1[5], b0[2], b1[2], rr[7]);

    for (genvar i = 0; i < 8; i++) begin : g_gate
      assign {cg0[8*k+i], cg1[8*k+i], ct0[8*k+i], ct1[8*k+i]} = gv[i];
    end

    assign bo0[8*k +: 8] = {p0[3], p0[0], p0[1], p0[6], p0[4], p0[2], p0[5], p0[7]};
    assign bo1[8*k +: 8] = {p1[3], p1[0], p1[1], p1[6], p1[4], p1[2], p1[5], p1[7]};
  end

  // Gates loaded in each layer state
  always_comb begin
    lmask = 8'h00;
    case (state_q)
      L1:      lmask = 8'b0000_0111;
      L2:      lmask = 8'b0001_1000;
      L3:      lmask = 8'b0110_0000;
      L4:      lmask = 8'b1000_0000;
      default: lmask = 8'h00;
    endcase
  end

  assign lsel = {NSBOX{lmask}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      L1:      state_d = L2;
      L2:      state_d = L3;
      L3:      state_d = L4;
      L4:      state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: state_d = IDLE;
    endcase
    out_hs = out_valid & out_ready;
    accept = in_valid & in_ready;
    if (accept) begin
      state_d = L1;
    end else if (out_hs) begin
      state_d = IDLE;
    end
  end

  // Layer load, then zeroize on release, then input capture (highest priority)
  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    r_d  = r_q;
    g0_d = (g0_q & ~lsel) | (cg0 & lsel);
    g1_d = (g1_q & ~lsel) | (cg1 & lsel);
    t0_d = (t0_q & ~lsel) | (ct0 & lsel);
    t1_d = (t1_q & ~lsel) | (ct1 & lsel);
    if (out_hs && ZEROIZE) begin
      s0_d = '0;
      s1_d = '0;
      r_d  = '0;
      g0_d = '0;
      g1_d = '0;
      t0_d = '0;
      t1_d = '0;
    end
    if (accept) begin
      s0_d = si0;
      s1_d = si1;
      r_d  = r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      r_q  <= '0;
      g0_q <= '0;
      g1_q <= '0;
      t0_q <= '0;
      t1_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      r_q  <= r_d;
      g0_q <= g0_d;
      g1_q <= g1_d;
      t0_q <= t0_d;
      t1_q <= t1_d;
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_dom1_sni_array.sv
// Directed bench for the masked SKINNY S8 array: known-answer table, full sweep,
// backpressure, back-to-back, zeroize and mid-operation reset.
module tb_skinny_sbox8_dom1_sni_array;

  localparam int unsigned NSBOX = 16;
  localparam int unsigned W     = 8 * NSBOX;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] si0, si1, r, bo0, bo1;

  int total;
  int bad;

  skinny_sbox8_dom1_sni_array #(.NSBOX(NSBOX), .ZEROIZE(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .si0      (si0),
    .si1      (si1),
    .r        (r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bo0      (bo0),
    .bo1      (bo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] u;
    logic [7:0] s;
  } vec_t;

  // Unmasked S8 built directly from the NOR/XOR round description
  function automatic logic [7:0] s8_ref(input logic [7:0] b);
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    a0 = ~(b[7] | b[6]) ^ b[4];
    a1 = ~(b[3] | b[2]) ^ b[0];
    a2 = ~(b[2] | b[1]) ^ b[6];
    a3 = ~(a0 | a1) ^ b[5];
    a4 = ~(a1 | b[3]) ^ b[1];
    a5 = ~(a2 | a3) ^ b[7];
    a6 = ~(a3 | a0) ^ b[3];
    a7 = ~(a4 | a5) ^ b[2];
    return {a3, a0, a1, a6, a4, a2, a5, a7};
  endfunction

  function automatic logic [W-1:0] exp_vec(input logic [W-1:0] u);
    logic [W-1:0] e;
    e = '0;
    for (int k = 0; k < int'(NSBOX); k++) e[8*k +: 8] = s8_ref(u[8*k +: 8]);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(W / 32); i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Present one input from IDLE; inputs are scrambled right after the accept edge
  task automatic start_op(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] rr);
    @(negedge clk);
    chk1("in_ready_idle", in_ready, 1'b1);
    si0 = a0;
    si1 = a1;
    r   = rr;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    si0 = rnd();
    si1 = rnd();
    r   = rnd();
  endtask

  // Count negedges until out_valid; bounded
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL timeout: out_valid never rose after %0d cycles", n);
    end
  endtask

  task automatic release_out(input bit check_idle);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (check_idle) begin
      @(negedge clk);
      chk1("idle_out_valid", out_valid, 1'b0);
      chk1("idle_in_ready", in_ready, 1'b1);
      chk("idle_bo0_zeroized", bo0, '0);
      chk("idle_bo1_zeroized", bo1, '0);
    end
  endtask

  vec_t         tbl[5];
  logic [W-1:0] m, u, rr, o0, o1, o0a;
  logic [W-1:0] zv, v65;
  int           lat;
  bit           saw;

  initial begin
    total = 0;
    bad   = 0;
    tbl[0] = '{u: 8'h00, s: 8'h65};
    tbl[1] = '{u: 8'h01, s: 8'h4C};
    tbl[2] = '{u: 8'h02, s: 8'h6A};
    tbl[3] = '{u: 8'h03, s: 8'h42};
    tbl[4] = '{u: 8'hFF, s: 8'hFF};
    zv  = '0;
    v65 = {NSBOX{8'h65}};

    // Asynchronous reset before any clock edge
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    si0 = '0; si1 = '0; r = '0;
    #1 rst_n = 1'b0;
    #2;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_bo0", bo0, '0);
    chk("rst_bo1", bo1, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero input, zero randomness, with latency
    start_op(zv, zv, zv);
    wait_done(lat);
    chk("zero_latency", W'(lat), W'(5));
    chk("zero_result", bo0 ^ bo1, v65);
    release_out(1'b1);

    // Known-answer table with random masks and randomness
    for (int i = 0; i < 5; i++) begin
      m  = rnd();
      rr = rnd();
      start_op(m, m ^ {NSBOX{tbl[i].u}}, rr);
      wait_done(lat);
      chk($sformatf("kat_%02h", tbl[i].u), bo0 ^ bo1, {NSBOX{tbl[i].s}});
      release_out(1'b0);
    end

    // Same unmasked 0xFF, two different refresh values
    m = rnd();
    start_op(m, ~m, rnd());
    wait_done(lat);
    o0a = bo0;
    chk("ones_r1", bo0 ^ bo1, {NSBOX{8'hFF}});
    release_out(1'b0);
    start_op(m, ~m, rnd());
    wait_done(lat);
    chk("ones_r2", bo0 ^ bo1, {NSBOX{8'hFF}});
    chk1("shares_differ", o0a != bo0, 1'b1);
    release_out(1'b0);

    // Sweep: every S-box sees every byte value
    for (int j = 0; j < 256; j++) begin
      u = '0;
      for (int k = 0; k < int'(NSBOX); k++) u[8*k +: 8] = 8'(j + 17 * k);
      m = rnd();
      start_op(m, m ^ u, rnd());
      wait_done(lat);
      chk($sformatf("sweep_%0d", j), bo0 ^ bo1, exp_vec(u));
      release_out(1'b0);
    end

    // Backpressure with ignored in_valid and changing inputs
    m = rnd();
    u = rnd();
    start_op(m, m ^ u, rnd());
    wait_done(lat);
    o0 = bo0;
    o1 = bo1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      si0 = rnd();
      si1 = rnd();
      r   = rnd();
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk("bp_bo0_stable", bo0, o0);
      chk("bp_bo1_stable", bo1, o1);
    end
    in_valid = 1'b0;
    chk("bp_result", bo0 ^ bo1, exp_vec(u));

    // Back-to-back: release and accept on the same edge
    m  = rnd();
    u  = rnd();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    si0 = m;
    si1 = m ^ u;
    r   = rnd();
    #1;
    chk1("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    si0 = rnd();
    si1 = rnd();
    r   = rnd();
    @(negedge clk);
    chk1("b2b_l1_out_valid", out_valid, 1'b0);
    chk("b2b_gates_cleared", bo0 | bo1, '0);
    wait_done(lat);
    chk("b2b_latency", W'(lat + 1), W'(5));
    chk("b2b_result", bo0 ^ bo1, exp_vec(u));
    release_out(1'b1);

    // Reset pulse during L3 aborts the operation
    m = rnd();
    start_op(m, ~m, rnd());
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_bo0", bo0, '0);
    chk("mid_rst_bo1", bo1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk1("mid_rst_no_output", saw, 1'b0);
    chk("mid_rst_bo_after", bo0 | bo1, '0);

    // Block is usable again after the abort
    m = rnd();
    u = rnd();
    start_op(m, m ^ u, rnd());
    wait_done(lat);
    chk("post_rst_latency", W'(lat), W'(5));
    chk("post_rst_result", bo0 ^ bo1, exp_vec(u));
    release_out(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
